// File: rtl/issue_unit_pkg.sv
// Shared definitions for the Tomasulo issue stage: opcodes, instruction
// field positions and the issue class of each opcode.
package issue_unit_pkg;

  localparam int INST_W     = 16;
  localparam int NUM_REGS   = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_NONE   = 0;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int A_MSB  = 11;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 4;
  localparam int C_MSB  = 3;
  localparam int C_LSB  = 0;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SD  = 4'b0010;
  localparam logic [3:0] OP_LD  = 4'b0011;

  typedef enum logic [1:0] {
    CLS_ARS = 2'd0,
    CLS_MEM = 2'd1,
    CLS_ILL = 2'd2
  } cls_e;

  function automatic cls_e op_class(input logic [3:0] op);
    cls_e cls;
    case (op)
      OP_ADD, OP_SUB: cls = CLS_ARS;
      OP_SD, OP_LD:   cls = CLS_MEM;
      default:        cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Two-entry instruction buffer between the instruction queue and the issue
// logic, including the credit (disponivel) generation towards the queue.
module issue_fifo
  import issue_unit_pkg::*;
(
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              push_i,
  input  logic [INST_W-1:0] data_i,
  input  logic              pop_i,
  output logic              head_valid_o,
  output logic [INST_W-1:0] head_o,
  output logic              disponivel_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [INST_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pending_q;
  logic              full_s, do_push_s, do_pop_s;

  assign full_s       = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_valid_o = (count_q != CNT_W'(0));
  assign head_o       = mem_q[rd_ptr_q];
  assign do_push_s    = push_i && !full_s;
  assign do_pop_s     = pop_i && head_valid_o;

  // A credit granted last cycle may still turn into a push, so it counts as occupied.
  assign disponivel_o = resetn_i &&
                        ((SUM_W'(count_q) + SUM_W'(pending_q)) < SUM_W'(FIFO_DEPTH));

  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= disponivel_o;
    end
  end

  issue_fifo_chk u_chk (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .push_i   (push_i),
    .full_i   (full_s)
  );

endmodule

// Protocol checker: the queue must never deliver into a full buffer.
module issue_fifo_chk (
  input logic clock_i,
  input logic resetn_i,
  input logic push_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clock_i) disable iff (!resetn_i) !(push_i && full_i));

endmodule

// File: rtl/issue_unit.sv
// Tomasulo issue stage: in-order decode of the buffered head instruction,
// slot allocation, operand read/forward and register renaming.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int NUM_ARS = 3,
  parameter int NUM_MEM = 3,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       instOutEn,
  input  logic [15:0]                instOut,
  output logic                       disponivel,
  output logic [3:0]                 rf_addr_j,
  output logic [3:0]                 rf_addr_k,
  input  logic [DATA_W-1:0]          rf_data_j,
  input  logic [DATA_W-1:0]          rf_data_k,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic [NUM_ARS+NUM_MEM-1:0] slot_release,
  output logic                       disp_valid,
  output logic [3:0]                 disp_op,
  output logic [TAG_W-1:0]           disp_tag,
  output logic [DATA_W-1:0]          disp_vj,
  output logic [DATA_W-1:0]          disp_vk,
  output logic [TAG_W-1:0]           disp_qj,
  output logic [TAG_W-1:0]           disp_qk,
  output logic [3:0]                 disp_imm,
  output logic                       illegal_op
);

  localparam int NUM_SLOTS = NUM_ARS + NUM_MEM;
  localparam int IDX_W     = $clog2(NUM_SLOTS);
  localparam logic [TAG_W-1:0] TAG_0 = TAG_W'(TAG_NONE);

  logic              head_valid_s, head_pop_s;
  logic [INST_W-1:0] head_s;
  logic [3:0]        op_s, fa_s, fb_s, fc_s;
  cls_e              cls_s;
  logic              ars_free_s, mem_free_s, slot_ok_s, issue_s, ill_s;
  logic [IDX_W-1:0]  ars_idx_s, mem_idx_s, slot_idx_s;
  logic [TAG_W-1:0]  slot_tag_s, tag_j_s, tag_k_s, qj_s, qk_s;
  logic [DATA_W-1:0] vj_s, vk_s;

  logic [NUM_SLOTS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]     rtag_q [NUM_REGS];
  logic [TAG_W-1:0]     rtag_d [NUM_REGS];

  logic              disp_valid_q, disp_valid_d, illegal_q, illegal_d;
  logic [3:0]        op_q, op_d, imm_q, imm_d;
  logic [TAG_W-1:0]  tag_q, tag_d, qj_q, qj_d, qk_q, qk_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;

  issue_fifo u_fifo (
    .clock_i      (clock),
    .resetn_i     (resetn),
    .push_i       (instOutEn),
    .data_i       (instOut),
    .pop_i        (head_pop_s),
    .head_valid_o (head_valid_s),
    .head_o       (head_s),
    .disponivel_o (disponivel)
  );

  assign op_s  = head_s[OP_MSB:OP_LSB];
  assign fa_s  = head_s[A_MSB:A_LSB];
  assign fb_s  = head_s[B_MSB:B_LSB];
  assign fc_s  = head_s[C_MSB:C_LSB];
  assign cls_s = op_class(op_s);

  // Downward scan so the lowest free index of each class wins.
  always_comb begin
    ars_free_s = 1'b0;
    ars_idx_s  = '0;
    mem_free_s = 1'b0;
    mem_idx_s  = '0;
    for (int i = NUM_ARS - 1; i >= 0; i--) begin
      ars_idx_s  = !busy_q[i] ? IDX_W'(i) : ars_idx_s;
      ars_free_s = ars_free_s | !busy_q[i];
    end
    for (int i = NUM_SLOTS - 1; i >= NUM_ARS; i--) begin
      mem_idx_s  = !busy_q[i] ? IDX_W'(i) : mem_idx_s;
      mem_free_s = mem_free_s | !busy_q[i];
    end
    case (cls_s)
      CLS_ARS: begin slot_ok_s = ars_free_s; slot_idx_s = ars_idx_s; end
      CLS_MEM: begin slot_ok_s = mem_free_s; slot_idx_s = mem_idx_s; end
      default: begin slot_ok_s = 1'b0;       slot_idx_s = '0;        end
    endcase
  end

  assign issue_s    = head_valid_s && slot_ok_s;
  assign ill_s      = head_valid_s && (cls_s == CLS_ILL);
  assign head_pop_s = issue_s || ill_s;
  assign slot_tag_s = TAG_W'(slot_idx_s) + TAG_W'(1);

  assign rf_addr_j = (cls_s == CLS_MEM) ? fc_s : fb_s;

  always_comb begin
    case (op_s)
      OP_ADD, OP_SUB: rf_addr_k = fc_s;
      OP_SD:          rf_addr_k = fa_s;
      default:        rf_addr_k = 4'd0;
    endcase
  end

  assign tag_j_s = rtag_q[rf_addr_j];
  assign tag_k_s = rtag_q[rf_addr_k];

  function automatic logic [TAG_W+DATA_W-1:0] resolve(
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] rf_data,
    input logic              cv,
    input logic [TAG_W-1:0]  ctag,
    input logic [DATA_W-1:0] cdata
  );
    if (tag == TAG_0) begin
      return {TAG_0, rf_data};
    end else if (cv && (ctag == tag)) begin
      return {TAG_0, cdata};
    end else begin
      return {tag, DATA_W'(0)};
    end
  endfunction

  assign {qj_s, vj_s} = resolve(tag_j_s, rf_data_j, cdb_valid, cdb_tag, cdb_data);

  always_comb begin
    if (op_s == OP_LD) begin
      {qk_s, vk_s} = '0;
    end else begin
      {qk_s, vk_s} = resolve(tag_k_s, rf_data_k, cdb_valid, cdb_tag, cdb_data);
    end
  end

  assign busy_d = (busy_q & ~slot_release) |
                  (issue_s ? (NUM_SLOTS'(1) << slot_idx_s) : NUM_SLOTS'(0));

  // A rename of the destination overrides a CDB clear of the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_s && (op_s != OP_SD) && (fa_s == 4'(r))) begin
        rtag_d[r] = slot_tag_s;
      end else if (cdb_valid && (rtag_q[r] == cdb_tag)) begin
        rtag_d[r] = TAG_0;
      end else begin
        rtag_d[r] = rtag_q[r];
      end
    end
  end

  always_comb begin
    disp_valid_d = issue_s;
    illegal_d    = ill_s;
    if (issue_s) begin
      op_d  = op_s;
      tag_d = slot_tag_s;
      vj_d  = vj_s;
      vk_d  = vk_s;
      qj_d  = qj_s;
      qk_d  = qk_s;
      imm_d = (cls_s == CLS_MEM) ? fb_s : 4'd0;
    end else begin
      op_d  = 4'd0;
      tag_d = TAG_0;
      vj_d  = '0;
      vk_d  = '0;
      qj_d  = TAG_0;
      qk_d  = TAG_0;
      imm_d = 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy_q       <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        rtag_q[r] <= TAG_0;
      end
      disp_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      op_q         <= 4'd0;
      tag_q        <= TAG_0;
      vj_q         <= '0;
      vk_q         <= '0;
      qj_q         <= TAG_0;
      qk_q         <= TAG_0;
      imm_q        <= 4'd0;
    end else begin
      busy_q       <= busy_d;
      rtag_q       <= rtag_d;
      disp_valid_q <= disp_valid_d;
      illegal_q    <= illegal_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      imm_q        <= imm_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign illegal_op = illegal_q;
  assign disp_op    = op_q;
  assign disp_tag   = tag_q;
  assign disp_vj    = vj_q;
  assign disp_vk    = vk_q;
  assign disp_qj    = qj_q;
  assign disp_qk    = qk_q;
  assign disp_imm   = imm_q;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: a vector table for single-instruction issue
// plus hand sequences for reset, stall/credit and slot release timing.
module tb_issue_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        instOutEn = 1'b0;
  logic [15:0] instOut = 16'h0000;
  logic        disponivel;
  logic [3:0]  rf_addr_j, rf_addr_k;
  logic [15:0] rf_data_j, rf_data_k;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = 3'd0;
  logic [15:0] cdb_data = 16'h0000;
  logic [5:0]  slot_release = 6'd0;
  logic        disp_valid, illegal_op;
  logic [3:0]  disp_op, disp_imm;
  logic [2:0]  disp_tag, disp_qj, disp_qk;
  logic [15:0] disp_vj, disp_vk;

  logic [15:0] rf_m [16];
  logic [15:0] q_m [$];
  logic        credit_r = 1'b0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [15:0] instr;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic [5:0]  rel;
    logic        ev;
    logic        ei;
    logic [3:0]  eop;
    logic [2:0]  etag;
    logic [15:0] evj;
    logic [15:0] evk;
    logic [2:0]  eqj;
    logic [2:0]  eqk;
    logic [3:0]  eimm;
  } vec_t;

  vec_t tv [9];

  issue_unit dut (
    .clock        (clock),
    .resetn       (resetn),
    .instOutEn    (instOutEn),
    .instOut      (instOut),
    .disponivel   (disponivel),
    .rf_addr_j    (rf_addr_j),
    .rf_addr_k    (rf_addr_k),
    .rf_data_j    (rf_data_j),
    .rf_data_k    (rf_data_k),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .slot_release (slot_release),
    .disp_valid   (disp_valid),
    .disp_op      (disp_op),
    .disp_tag     (disp_tag),
    .disp_vj      (disp_vj),
    .disp_vk      (disp_vk),
    .disp_qj      (disp_qj),
    .disp_qk      (disp_qk),
    .disp_imm     (disp_imm),
    .illegal_op   (illegal_op)
  );

  initial forever #5 clock = ~clock;

  assign rf_data_j = rf_m[rf_addr_j];
  assign rf_data_k = rf_m[rf_addr_k];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: queue model delivers an instruction one cycle after seeing credit.
  task automatic step();
    @(negedge clock);
    if (credit_r && (q_m.size() > 0)) begin
      instOutEn = 1'b1;
      instOut   = q_m.pop_front();
    end else begin
      instOutEn = 1'b0;
      instOut   = 16'h0000;
    end
    credit_r = disponivel;
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    q_m.push_back(v.instr);
    step();
    step();
    cdb_valid    = v.cv;
    cdb_tag      = v.ct;
    cdb_data     = v.cd;
    slot_release = v.rel;
    step();
    cdb_valid    = 1'b0;
    cdb_tag      = 3'd0;
    cdb_data     = 16'h0000;
    slot_release = 6'd0;
    chk({nm, ".valid"},   16'(disp_valid), 16'(v.ev));
    chk({nm, ".illegal"}, 16'(illegal_op), 16'(v.ei));
    chk({nm, ".op"},      16'(disp_op),    16'(v.eop));
    chk({nm, ".tag"},     16'(disp_tag),   16'(v.etag));
    chk({nm, ".vj"},      disp_vj,         v.evj);
    chk({nm, ".vk"},      disp_vk,         v.evk);
    chk({nm, ".qj"},      16'(disp_qj),    16'(v.eqj));
    chk({nm, ".qk"},      16'(disp_qk),    16'(v.eqk));
    chk({nm, ".imm"},     16'(disp_imm),   16'(v.eimm));
  endtask

  initial begin
    int         n;
    int         seen;
    logic [2:0] got_tag [3];

    for (int i = 0; i < 16; i++) rf_m[i] = 16'h1000 + 16'(i);
    rf_m[1] = 16'h0005;
    rf_m[2] = 16'h0007;

    //          instr     cv    ct    cd        rel        ev    ei    op    tag   vj        vk        qj    qk    imm
    tv[0] = '{16'h0312, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b1, 1'b0, 4'h0, 3'd1, 16'h0005, 16'h0007, 3'd0, 3'd0, 4'h0};
    tv[1] = '{16'h1531, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b1, 1'b0, 4'h1, 3'd2, 16'h0000, 16'h0005, 3'd1, 3'd0, 4'h0};
    tv[2] = '{16'h1631, 1'b1, 3'd1, 16'h00AA, 6'b000001, 1'b1, 1'b0, 4'h1, 3'd3, 16'h00AA, 16'h0005, 3'd0, 3'd0, 4'h0};
    tv[3] = '{16'h3104, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b1, 1'b0, 4'h3, 3'd4, 16'h1004, 16'h0000, 3'd0, 3'd0, 4'h0};
    tv[4] = '{16'h2504, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b1, 1'b0, 4'h2, 3'd5, 16'h1004, 16'h0000, 3'd0, 3'd2, 4'h0};
    tv[5] = '{16'h2321, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b1, 1'b0, 4'h2, 3'd6, 16'h0000, 16'h1003, 3'd4, 3'd0, 4'h2};
    tv[6] = '{16'h7123, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b0, 1'b1, 4'h0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd0, 4'h0};
    tv[7] = '{16'h0112, 1'b1, 3'd4, 16'h0BEE, 6'b000010, 1'b1, 1'b0, 4'h0, 3'd1, 16'h0BEE, 16'h0007, 3'd0, 3'd0, 4'h0};
    tv[8] = '{16'h0210, 1'b0, 3'd0, 16'h0000, 6'b000000, 1'b1, 1'b0, 4'h0, 3'd2, 16'h0000, 16'h1000, 3'd1, 3'd0, 4'h0};

    // Power-on reset
    resetn = 1'b0;
    repeat (3) step();
    chk("rst.disponivel", 16'(disponivel), 16'h0000);
    chk("rst.valid",      16'(disp_valid), 16'h0000);
    chk("rst.illegal",    16'(illegal_op), 16'h0000);
    chk("rst.vj",         disp_vj,         16'h0000);
    resetn = 1'b1;
    repeat (4) step();

    for (int i = 0; i < 9; i++) begin
      apply_vec(tv[i], $sformatf("vec%0d", i));
    end

    // Reset while an instruction sits in the buffer
    q_m.push_back(16'h0712);
    step();
    resetn = 1'b0;
    step();
    step();
    chk("midrst.disponivel", 16'(disponivel), 16'h0000);
    chk("midrst.valid",      16'(disp_valid), 16'h0000);
    chk("midrst.illegal",    16'(illegal_op), 16'h0000);
    chk("midrst.tag",        16'(disp_tag),   16'h0000);
    chk("midrst.vj",         disp_vj,         16'h0000);
    chk("midrst.qk",         16'(disp_qk),    16'h0000);
    resetn = 1'b1;
    q_m.delete();
    credit_r = 1'b0;
    seen = 0;
    repeat (4) begin
      step();
      if (disp_valid) seen++;
    end
    chk("midrst.discarded", 16'(seen), 16'h0000);

    // Five ADDs with no releases: three issue, the rest back up and close the credit
    q_m.push_back(16'h0756);
    q_m.push_back(16'h0856);
    q_m.push_back(16'h0956);
    q_m.push_back(16'h0A56);
    q_m.push_back(16'h0B56);
    n = 0;
    repeat (20) begin
      step();
      if (disp_valid) begin
        if (n < 3) got_tag[n] = disp_tag;
        if (n == 0) begin
          chk("stall.first.vj", disp_vj,         16'h1005);
          chk("stall.first.vk", disp_vk,         16'h1006);
          chk("stall.first.qj", 16'(disp_qj),    16'h0000);
          chk("stall.first.qk", 16'(disp_qk),    16'h0000);
        end
        n++;
      end
    end
    chk("stall.count", 16'(n), 16'h0003);
    if (n >= 3) begin
      chk("stall.tag0", 16'(got_tag[0]), 16'h0001);
      chk("stall.tag1", 16'(got_tag[1]), 16'h0002);
      chk("stall.tag2", 16'(got_tag[2]), 16'h0003);
    end
    chk("stall.disponivel", 16'(disponivel), 16'h0000);
    chk("stall.valid",      16'(disp_valid), 16'h0000);

    // Release slot tag 1: usable the cycle after the release edge, not before
    slot_release = 6'b000001;
    step();
    slot_release = 6'b000000;
    chk("rel1.same_cycle", 16'(disp_valid), 16'h0000);
    step();
    chk("rel1.valid", 16'(disp_valid), 16'h0001);
    chk("rel1.tag",   16'(disp_tag),   16'h0001);
    chk("rel1.op",    16'(disp_op),    16'h0000);
    chk("rel1.vj",    disp_vj,         16'h1005);

    slot_release = 6'b000010;
    step();
    slot_release = 6'b000000;
    step();
    chk("rel2.valid", 16'(disp_valid), 16'h0001);
    chk("rel2.tag",   16'(disp_tag),   16'h0002);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Tomasulo issue stage, directly downstream of the instruction queue.
- Accepts 16-bit instructions through the queue's disponivel/instOutEn/instOut handshake and buffers them in a 2-entry FIFO.
- Decodes and issues in order, one per cycle, to a free reservation station (ADD/SUB) or memory buffer (LD/SD).
- Reads operands from the register file or renames them through a register status table snooping the CDB.

Parameters:
- NUM_ARS, 3, ADD/SUB reservation stations (tags 1..NUM_ARS).
- NUM_MEM, 3, load/store buffers (tags NUM_ARS+1..NUM_ARS+NUM_MEM).
- DATA_W, 16, operand width.
- TAG_W, 3, tag width; tag 0 = "value ready".

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- instOutEn  in  1  instruction valid from queue, one cycle after disponivel sampled high.
- instOut  in  16  instruction {op[15:12], a[11:8], b[7:4], c[3:0]}.
- disponivel  out  1  credit request to queue.
- rf_addr_j, rf_addr_k  out  4  register file read addresses (combinational read).
- rf_data_j, rf_data_k  in  DATA_W  register file read data.
- cdb_valid  in  1  common data bus broadcast.
- cdb_tag  in  TAG_W  producing tag.
- cdb_data  in  DATA_W  result.
- slot_release  in  NUM_ARS+NUM_MEM  one-hot-per-slot free pulses from RS/buffers; bit i = tag i+1.
- disp_valid  out  1  dispatch pulse.
- disp_op  out  4  opcode.
- disp_tag  out  TAG_W  allocated slot tag.
- disp_vj, disp_vk  out  DATA_W  operand values.
- disp_qj, disp_qk  out  TAG_W  operand tags (0 = value valid).
- disp_imm  out  4  LD/SD offset.
- illegal_op  out  1  pulse, undefined opcode dropped.

Behaviour:
- Reset (resetn=0 at rising edge): FIFO empty, pending=0, all slots free, all register tags 0. Outputs disp_valid=0, illegal_op=0, all disp_* buses 0. disponivel=0 while resetn=0.
- Opcodes:
  - 0000 ADD a←b+c.
  - 0001 SUB a←b−c.
  - 0010 SD: store reg a at b(reg c).
  - 0011 LD: a←mem[b+reg c].
  - Others illegal.
- Operands:
  - ADD/SUB: j=b, k=c.
  - LD: j=c, k unused (qk=0, vk=0).
  - SD: j=c, k=a.
  - disp_imm=b for LD/SD, 0 otherwise.
- Credit:
  - pending is a register holding last cycle's disponivel.
  - disponivel = resetn && (count + pending < 2), combinational from registers.
  - instOutEn writes the FIFO tail; the FIFO never overflows.
  - instOutEn while the FIFO is full is a protocol error and is covered by an assertion.
- Issue (combinational decision on FIFO head, registered outputs):
  - The head issues when its class (ARS for 0000/0001, MEM for 0010/0011) has a free slot. The lowest free index is allocated and marked busy.
  - Otherwise the head stalls and later entries wait: strictly in order.
  - Illegal head: popped, illegal_op=1 for one cycle, no allocation.
- Latency: instOutEn at cycle t → earliest disp_valid at t+2. Sustained throughput is 1 issue/cycle when slots are free.
- Operand read per source register r:
  - If tag[r]==0: v=rf_data, q=0.
  - If cdb_valid && cdb_tag==tag[r] in the issue cycle: v=cdb_data, q=0 (forward).
  - Otherwise q=tag[r], v=0.
- Rename: ADD/SUB/LD write tag[a]=allocated tag. SD writes no tag.
- CDB: each register with tag==cdb_tag is cleared to 0.
  - Simultaneous clear and rename of the same register: the rename wins.
  - A source equal to the destination (ADD R1,R1,R2) reads the old tag/value before the rename.
- slot_release frees slots at the edge. A freed slot is allocatable the following cycle, not the same cycle.
- Simultaneous release and allocate of different slots are both honoured.
- Mid-operation reset clears all state. Dispatched slots and an in-flight queue output are discarded. Instructions already taken from the queue are lost; the system is reset together.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD/OP_SUB/OP_SD/OP_LD;
  - TAG_NONE=0;
  - field index constants for op/a/b/c;
  - class enum {CLS_ARS, CLS_MEM, CLS_ILL}.
- One natural sub-module, issue_fifo: 2-entry FIFO with the credit counter and disponivel generation.
- Register status table, slot bitmaps and dispatch logic stay in issue_unit.

Test Plan:
- Reset, then ADD R3,R1,R2 (0x0312) with R1=5, R2=7, all tags 0 → disp_valid at t+2, op=0, tag=1, vj=5, vk=7, qj=qk=0; tag[R3]=1.
- ADD R3,R1,R2 then SUB R5,R3,R1 (0x1531) → SUB gets tag=2, qj=1, vj=0, qk=0, vk=R1 value.
- CDB valid with tag=1, data=0x00AA in the SUB's issue cycle → SUB vj=0x00AA, qj=0; tag[R3] cleared.
- Four ADDs, no release → tags 1,2,3 issue; 4th stalls, with disponivel low once FIFO and pending are full. slot_release bit0 pulse → 4th issues next cycle with tag=1.
- LD R1,0(R4) (0x3104) then SD R5,0(R4) (0x2504) while tag[R5]=2 → LD tag=4, qj=0; SD tag=5, qk=2, imm=0; tag[R1]=4, SD renames nothing.
- Instruction 0x7123 → illegal_op pulse, no disp_valid, no state change.
- resetn low mid-stream → all outputs 0, all tags 0.
